// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 Hz VGA path.
// Renderers import this package for the visible-area constants used in
// address scaling; the timing generator uses it for its default geometry.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // Counter width for DrawX/DrawY and width of the frame counter.
  localparam int CNT_W   = 10;
  localparam int FRAME_W = 16;

  // Total period (pixels per line or lines per frame) of one axis.
  function automatic int timing_total(input int visible, input int front,
                                      input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage, 1-bit shift register with a synchronous reset value.
// Used to align hs/vs with the renderer's registered RGB output.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset; loads RST_VAL into every stage
//   d_i    input bit
//   q_o    input bit delayed by DEPTH cycles (combinational pass-through when DEPTH=0)
module sync_delay_line #(
  parameter int   DEPTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sr_q <= {DEPTH{RST_VAL}};
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator for the VGA path.
// Produces the current pixel position (DrawX/DrawY), the visible-area flag
// (blank), line/frame strobes and a completed-frame counter, all registered
// and describing the same pixel in the same cycle. hs/vs are additionally
// delayed by SYNC_DELAY cycles to line up with the renderer's RGB register.
// Ports:
//   vga_clk      pixel clock
//   reset        synchronous active-high reset
//   DrawX/DrawY  current horizontal / vertical count
//   blank        1 = visible pixel, 0 = blanking
//   hs/vs        sync outputs (asserted level SYNC_ACTIVE), delayed SYNC_DELAY
//   line_start   1 when DrawX == 0
//   frame_start  1 when DrawX == 0 and DrawY == 0
//   frame_count  completed-frame counter, wraps at 16 bits
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_DEF,
  parameter int   H_FRONT     = H_FRONT_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BACK      = H_BACK_DEF,
  parameter int   V_VISIBLE   = V_VISIBLE_DEF,
  parameter int   V_FRONT     = V_FRONT_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BACK      = V_BACK_DEF,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   SYNC_DELAY  = 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  output logic [CNT_W-1:0]   DrawX,
  output logic [CNT_W-1:0]   DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0]   hc_q, hc_d;
  logic [CNT_W-1:0]   vc_q, vc_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               blank_q, blank_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               hs_raw_q, hs_raw_d;
  logic               vs_raw_q, vs_raw_d;

  always_comb begin
    hc_d          = hc_q + CNT_W'(1);
    vc_d          = vc_q;
    frame_count_d = frame_count_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d          = '0;
        frame_count_d = frame_count_q + FRAME_W'(1);
      end else begin
        vc_d = vc_q + CNT_W'(1);
      end
    end

    // Decoding from the next-state counts makes every registered flag
    // describe the same pixel as the registered DrawX/DrawY.
    blank_d       = (hc_d < H_VIS_C) && (vc_d < V_VIS_C);
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
    hs_raw_d      = ((hc_d >= HS_FIRST) && (hc_d <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_raw_d      = ((vc_d >= VS_FIRST) && (vc_d <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      frame_count_q <= '0;
      blank_q       <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      hs_raw_q      <= ~SYNC_ACTIVE;
      vs_raw_q      <= ~SYNC_ACTIVE;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_count_q <= frame_count_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
    end
  end

  sync_delay_line #(
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (~SYNC_ACTIVE)
  ) u_hs_delay (
    .clk_i (vga_clk),
    .rst_i (reset),
    .d_i   (hs_raw_q),
    .q_o   (hs)
  );

  sync_delay_line #(
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (~SYNC_ACTIVE)
  ) u_vs_delay (
    .clk_i (vga_clk),
    .rst_i (reset),
    .d_i   (vs_raw_q),
    .q_o   (vs)
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Five instances share clock and reset:
//   main : full 640x480 timing, SYNC_DELAY=1
//   d0   : full timing, SYNC_DELAY=0
//   d3   : full timing, SYNC_DELAY=3
//   mini : 15x10 timing (8/2/3/2, 6/1/2/1), SYNC_DELAY=1, for frame-level events
//   tiny : 1x1 timing, one frame per cycle, for the frame_count wrap
module tb_vga_timing_gen;

  logic vga_clk;
  logic reset;

  logic [9:0]  m_x, m_y, z_x, z_y, t_x, t_y, n_x, n_y, y_x, y_y;
  logic        m_b, m_hs, m_vs, m_ls, m_fs;
  logic        z_b, z_hs, z_vs, z_ls, z_fs;
  logic        t_b, t_hs, t_vs, t_ls, t_fs;
  logic        n_b, n_hs, n_vs, n_ls, n_fs;
  logic        y_b, y_hs, y_vs, y_ls, y_fs;
  logic [15:0] m_fc, z_fc, t_fc, n_fc, y_fc;

  int n_tests = 0;
  int n_fail  = 0;
  int t;
  int vs_start, vs_end, vs_len, fs_prev, glitches;

  vga_timing_gen u_main (
    .vga_clk(vga_clk), .reset(reset), .DrawX(m_x), .DrawY(m_y), .blank(m_b),
    .hs(m_hs), .vs(m_vs), .line_start(m_ls), .frame_start(m_fs), .frame_count(m_fc));

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(z_x), .DrawY(z_y), .blank(z_b),
    .hs(z_hs), .vs(z_vs), .line_start(z_ls), .frame_start(z_fs), .frame_count(z_fc));

  vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(t_x), .DrawY(t_y), .blank(t_b),
    .hs(t_hs), .vs(t_vs), .line_start(t_ls), .frame_start(t_fs), .frame_count(t_fc));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(1)
  ) u_mini (
    .vga_clk(vga_clk), .reset(reset), .DrawX(n_x), .DrawY(n_y), .blank(n_b),
    .hs(n_hs), .vs(n_vs), .line_start(n_ls), .frame_start(n_fs), .frame_count(n_fc));

  vga_timing_gen #(
    .H_VISIBLE(1), .H_FRONT(0), .H_SYNC(0), .H_BACK(0),
    .V_VISIBLE(1), .V_FRONT(0), .V_SYNC(0), .V_BACK(0), .SYNC_DELAY(0)
  ) u_tiny (
    .vga_clk(vga_clk), .reset(reset), .DrawX(y_x), .DrawY(y_y), .blank(y_b),
    .hs(y_hs), .vs(y_vs), .line_start(y_ls), .frame_start(y_fs), .frame_count(y_fc));

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_x"},  m_x,  0);
    check_eq({tag, "_y"},  m_y,  0);
    check_eq({tag, "_b"},  m_b,  1);
    check_eq({tag, "_ls"}, m_ls, 1);
    check_eq({tag, "_fs"}, m_fs, 1);
    check_eq({tag, "_fc"}, m_fc, 0);
    check_eq({tag, "_hs"}, m_hs, 1);
    check_eq({tag, "_vs"}, m_vs, 1);
    check_eq({tag, "_d3hs"}, t_hs, 1);
    check_eq({tag, "_mini_x"},  n_x,  0);
    check_eq({tag, "_mini_y"},  n_y,  0);
    check_eq({tag, "_mini_fc"}, n_fc, 0);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk);
      check_reset_state($sformatf("rst%0d", k));
    end
    reset = 1'b0;

    // t counts cycles since the last reset cycle (t=0 is the reset state).
    t = 0; vs_start = -1; vs_end = -1; vs_len = 0; fs_prev = 0;
    while (t < 1100) begin
      if (t < 800) begin
        check_eq($sformatf("line_x@%0d", t),  m_x,  t);
        check_eq($sformatf("line_y@%0d", t),  m_y,  0);
        check_eq($sformatf("line_b@%0d", t),  m_b,  (t < 640));
        check_eq($sformatf("line_ls@%0d", t), m_ls, (t == 0));
        check_eq($sformatf("line_fs@%0d", t), m_fs, (t == 0));
        check_eq($sformatf("line_vs@%0d", t), m_vs, 1);
        check_eq($sformatf("hs_d1@%0d", t), m_hs, !(t >= 657 && t <= 752));
        check_eq($sformatf("hs_d0@%0d", t), z_hs, !(t >= 656 && t <= 751));
        check_eq($sformatf("hs_d3@%0d", t), t_hs, !(t >= 659 && t <= 754));
      end
      if (t == 800) begin
        check_eq("wrap_x", m_x, 0);
        check_eq("wrap_y", m_y, 1);
        check_eq("wrap_ls", m_ls, 1);
        check_eq("wrap_fs", m_fs, 0);
        check_eq("wrap_b", m_b, 1);
      end

      // mini timing: 15 pixels per line, 10 lines per frame
      check_eq($sformatf("mini_x@%0d", t),  n_x,  t % 15);
      check_eq($sformatf("mini_y@%0d", t),  n_y,  (t / 15) % 10);
      check_eq($sformatf("mini_fc@%0d", t), n_fc, t / 150);
      check_eq($sformatf("mini_b@%0d", t),  n_b,  ((t % 15) < 8) && (((t / 15) % 10) < 6));
      check_eq($sformatf("mini_ls@%0d", t), n_ls, (t % 15) == 0);
      check_eq($sformatf("mini_fs@%0d", t), n_fs, (t % 150) == 0);
      check_eq($sformatf("mini_hs@%0d", t), n_hs,
               !(t >= 1 && ((t - 1) % 15) >= 10 && ((t - 1) % 15) <= 12));
      check_eq($sformatf("mini_vs@%0d", t), n_vs,
               !(t >= 1 && (((t - 1) / 15) % 10) >= 7 && (((t - 1) / 15) % 10) <= 8));
      check_eq($sformatf("tiny_fc@%0d", t), y_fc, t);

      // hand-picked mini frame events
      if (t == 134) begin check_eq("mini_pre_x", n_x, 14); check_eq("mini_pre_y", n_y, 8); end
      if (t == 135) begin check_eq("mini_l9_x", n_x, 0); check_eq("mini_l9_y", n_y, 9); end
      if (t == 149) begin
        check_eq("mini_last_x", n_x, 14); check_eq("mini_last_y", n_y, 9);
        check_eq("mini_last_fc", n_fc, 0); check_eq("mini_last_fs", n_fs, 0);
      end
      if (t == 150) begin
        check_eq("mini_f1_x", n_x, 0); check_eq("mini_f1_y", n_y, 0);
        check_eq("mini_f1_fs", n_fs, 1); check_eq("mini_f1_fc", n_fc, 1);
      end

      if (t < 150 && n_vs == 1'b0) begin
        if (vs_start < 0) vs_start = t;
        vs_end = t;
        vs_len++;
      end
      if (t > 0 && n_fs == 1'b1) begin
        check_eq($sformatf("mini_fs_period@%0d", t), t - fs_prev, 150);
        fs_prev = t;
      end

      @(negedge vga_clk);
      t++;
    end

    check_eq("mini_vs_start", vs_start, 106);
    check_eq("mini_vs_len", vs_len, 30);
    check_eq("mini_vs_span", vs_end - vs_start + 1, 30);

    // mid-frame reset
    check_eq("pre_rst_x", m_x, 300);
    check_eq("pre_rst_y", m_y, 1);
    check_eq("pre_rst_mini_x", n_x, 5);
    check_eq("pre_rst_mini_y", n_y, 3);
    check_eq("pre_rst_mini_fc", n_fc, 7);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge vga_clk);
      check_reset_state($sformatf("midrst%0d", k));
    end
    reset = 1'b0;
    t = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge vga_clk);
      t++;
      check_eq($sformatf("resume_x%0d", k), m_x, k);
      check_eq($sformatf("resume_y%0d", k), m_y, 0);
      check_eq($sformatf("resume_fc%0d", k), m_fc, 0);
      check_eq($sformatf("resume_mini_fc%0d", k), n_fc, 0);
    end
    check_eq("tiny_fc_resume", y_fc, 4);

    // one frame per cycle on the tiny instance: run through the 16-bit wrap
    glitches = 0;
    while (t < 65535) begin
      @(negedge vga_clk);
      t++;
      if (y_fs !== 1'b1) glitches++;
    end
    check_eq("tiny_fc_ffff", y_fc, 16'hFFFF);
    @(negedge vga_clk);
    t++;
    check_eq("tiny_fc_wrap", y_fc, 0);
    check_eq("tiny_fs_wrap", y_fs, 1);
    check_eq("tiny_fs_glitches", glitches, 0);
    check_eq("long_main_x", m_x, 736);
    check_eq("long_main_y", m_y, 81);
    check_eq("long_main_hs", m_hs, 0);
    check_eq("long_main_vs", m_vs, 1);
    check_eq("long_main_fc", m_fc, 0);
    check_eq("long_mini_x", n_x, 1);
    check_eq("long_mini_y", n_y, 9);
    check_eq("long_mini_fc", n_fc, 436);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Pixel-timing generator for the 640x480@60 Hz VGA path, sitting directly upstream of the sprite and scene renderers. It produces DrawX/DrawY/blank, which drive a renderer's ROM address and colour gating, plus hsync/vsync. The sync outputs are delayed to line up with the renderer's registered RGB output. It also emits frame and line strobes and a frame counter for animation logic.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 1'b0, asserted level of hs/vs
SYNC_DELAY, 1, cycles hs/vs lag DrawX/DrawY (matches renderer RGB register stage); legal 0..4

Ports:
vga_clk  input  1  pixel clock (25 MHz); one clock, all state on posedge
reset  input  1  synchronous, active-high reset
DrawX  output  10  current horizontal count, 0..H_TOTAL-1
DrawY  output  10  current vertical count, 0..V_TOTAL-1
blank  output  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
hs  output  1  horizontal sync, delayed SYNC_DELAY cycles
vs  output  1  vertical sync, delayed SYNC_DELAY cycles
line_start  output  1  high for the one cycle where DrawX==0
frame_start  output  1  high for the one cycle where DrawX==0 and DrawY==0
frame_count  output  16  completed-frame counter

Behaviour:
- Derived widths and totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Horizontal counter hc:
  - Increments every cycle.
  - At H_TOTAL-1 it wraps to 0, and the vertical counter vc increments.
- Vertical counter vc: at V_TOTAL-1 with hc at H_TOTAL-1, vc wraps to 0.
- All outputs are registered and describe the same pixel in the same cycle:
  - DrawX = hc, DrawY = vc.
  - blank and the strobes are decoded from the next-state counter values, so there is zero skew against DrawX/DrawY.
- Raw sync (undelayed):
  - hs_raw active for hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vs_raw active for vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491, for every hc on those lines.
- hs/vs: hs_raw and vs_raw pass through a SYNC_DELAY-stage shift register. With SYNC_DELAY=0 they equal the raw values in the same cycle.
- frame_count:
  - Increments by 1 in the cycle the counters wrap from (799,524) to (0,0).
  - Wraps 0xFFFF -> 0x0000.
- Reset, in the cycle after reset is sampled high:
  - DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=0.
  - hs=vs=~SYNC_ACTIVE, and every delay stage is loaded with the inactive level.
- Reset held for several cycles: outputs stay at the reset values.
- Reset mid-frame (any hc/vc): takes effect the next cycle, with no partial line and no frame_count increment.
- First valid hs assertion after reset is at DrawX=656+SYNC_DELAY of line 0.
- No other inputs exist; no enable or handshake. The downstream renderer samples DrawX/DrawY/blank every cycle.

Decomposition:
- Package vga_timing_pkg holds the default timing constants (640/16/96/48, 480/10/2/33) and a function computing H_TOTAL/V_TOTAL. Renderers reuse the visible-area constants for address scaling.
- One sub-module, sync_delay_line, is a parameterised DEPTH x 1-bit shift register with a synchronous reset value. It is instantiated twice, once for hs and once for vs.

Test Plan:
- Reset then free-run one line: DrawX steps 0..799; blank=1 for DrawX 0..639 and 0 for 640..799; line_start high only at DrawX=0. With SYNC_DELAY=1, hs is low exactly in the cycles where DrawX=657..752 (mod 800, i.e. low during DrawX 657..752).
- Line/frame wrap:
  - At (799,523) the next cycle is (0,524).
  - At (799,524) the next cycle is (0,0), with frame_start=1 and frame_count going 0->1.
  - blank=0 for all of lines 480..524.
- Vertical sync: vs low for exactly 2x800=1600 consecutive cycles, starting one cycle after DrawY first equals 490 at DrawX=0. There are 525x800=420000 cycles between successive frame_start pulses.
- Reset mid-frame: assert reset at (300,200) for 3 cycles. Every cycle during reset shows (0,0), blank=1, hs=vs=1, frame_count unchanged-to-0. Counting resumes 1,2,... after release.
- frame_count wrap: force-run (or reduce V/H parameters to a 4x3 mini-timing) through 65536 frames -> frame_count returns to 0x0000 with no glitch on frame_start.
- SYNC_DELAY=0 and SYNC_DELAY=3 builds: hs assertion edge lands at DrawX=656 and DrawX=659 respectively, with width unchanged at 96.
